// File: rtl/bus_io_responder.sv
// Memory-mapped I/O responder for the CPU bus.
// Provides a six-register window: LEDs, switches, hex display value, and a
// compare timer with interrupt. DTAck can be delayed by programmable wait states.
// Data_Out is zero whenever no read is being acknowledged, so the result can be
// OR-combined with other bus targets.
module bus_io_responder #(
  parameter int WAIT_STATES = 1,
  parameter int SW_WIDTH    = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                AS_L,
  input  logic                WE_L,
  input  logic                IO_Select_H,
  input  logic [9:0]          Address,
  input  logic [3:0]          Byte_Enable,
  input  logic [31:0]         Data_In,
  output logic [31:0]         Data_Out,
  output logic                DTAck,
  input  logic [SW_WIDTH-1:0] SW_input,
  output logic [SW_WIDTH-1:0] LEDR_output,
  output logic [23:0]         HEX_value,
  output logic                irq
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_ACK  = 2'd2;

  localparam logic [3:0] WS = 4'(WAIT_STATES);

  localparam logic [2:0] REG_LEDR    = 3'd0;
  localparam logic [2:0] REG_SW      = 3'd1;
  localparam logic [2:0] REG_HEX     = 3'd2;
  localparam logic [2:0] REG_COUNT   = 3'd3;
  localparam logic [2:0] REG_COMPARE = 3'd4;
  localparam logic [2:0] REG_CTRL    = 3'd5;

  logic [1:0]          state;
  logic [3:0]          wait_cnt;
  logic [2:0]          lat_reg;
  logic                lat_we_l;
  logic [3:0]          lat_be;
  logic [31:0]         lat_data;

  logic [SW_WIDTH-1:0] ledr;
  logic [SW_WIDTH-1:0] sw_meta;
  logic [SW_WIDTH-1:0] sw_sync;
  logic [23:0]         hex;
  logic [31:0]         count;
  logic [31:0]         compare;
  logic                tmr_en;
  logic                tmr_auto;
  logic                tmr_expired;
  logic                tmr_irq_en;

  logic                start;
  logic                enter_ack;
  logic [2:0]          acc_reg;
  logic                acc_we_l;
  logic [3:0]          acc_be;
  logic [31:0]         acc_data;
  logic [31:0]         rdata;
  logic [31:0]         merged;
  logic                wr_commit;
  logic                hw_match;

  logic                unused_addr_bits;
  assign unused_addr_bits = ^{Address[9:5], Address[1:0]};

  // Access qualification and the edge on which the transfer completes.
  always_comb begin
    start     = (state == ST_IDLE) && !AS_L && IO_Select_H;
    enter_ack = (start && (WS == 4'd0)) ||
                ((state == ST_WAIT) && !AS_L && (wait_cnt == 4'd1));
    acc_reg   = (state == ST_IDLE) ? Address[4:2] : lat_reg;
    acc_we_l  = (state == ST_IDLE) ? WE_L        : lat_we_l;
    acc_be    = (state == ST_IDLE) ? Byte_Enable : lat_be;
    acc_data  = (state == ST_IDLE) ? Data_In     : lat_data;
    wr_commit = enter_ack && !acc_we_l;
    hw_match  = tmr_en && (count == compare);
  end

  // Read mux of the addressed register; unused bits and offsets 6/7 read zero.
  always_comb begin
    rdata = 32'd0;
    case (acc_reg)
      REG_LEDR:    rdata = 32'(ledr);
      REG_SW:      rdata = 32'(sw_sync);
      REG_HEX:     rdata = {8'd0, hex};
      REG_COUNT:   rdata = count;
      REG_COMPARE: rdata = compare;
      REG_CTRL:    rdata = {28'd0, tmr_irq_en, tmr_expired, tmr_auto, tmr_en};
      default:     rdata = 32'd0;
    endcase
  end

  // Merge write data into the current register value on enabled byte lanes only.
  always_comb begin
    merged = rdata;
    for (int i = 0; i < 4; i++) begin
      if (acc_be[i]) merged[8*i +: 8] = acc_data[8*i +: 8];
    end
  end

  // Bus handshake FSM: latch the request, count wait states, hold DTAck until AS_L rises.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
      lat_reg  <= 3'd0;
      lat_we_l <= 1'b1;
      lat_be   <= 4'd0;
      lat_data <= 32'd0;
      DTAck    <= 1'b0;
      Data_Out <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            lat_reg  <= Address[4:2];
            lat_we_l <= WE_L;
            lat_be   <= Byte_Enable;
            lat_data <= Data_In;
            wait_cnt <= WS;
            state    <= (WS == 4'd0) ? ST_ACK : ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (AS_L) begin
            state <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt - 4'd1;
            if (wait_cnt == 4'd1) state <= ST_ACK;
          end
        end
        ST_ACK: begin
          if (AS_L) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase

      if (enter_ack) begin
        DTAck    <= 1'b1;
        Data_Out <= acc_we_l ? rdata : 32'd0;
      end else if ((state == ST_ACK) && AS_L) begin
        DTAck    <= 1'b0;
        Data_Out <= 32'd0;
      end
    end
  end

  // Two-flop synchronizer for the asynchronous switch inputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_meta <= '0;
      sw_sync <= '0;
    end else begin
      sw_meta <= SW_input;
      sw_sync <= sw_meta;
    end
  end

  // LED, hex and compare registers take committed writes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ledr    <= '0;
      hex     <= 24'd0;
      compare <= 32'd0;
    end else if (wr_commit) begin
      case (acc_reg)
        REG_LEDR:    ledr    <= merged[SW_WIDTH-1:0];
        REG_HEX:     hex     <= merged[23:0];
        REG_COMPARE: compare <= merged;
        default:     ;
      endcase
    end
  end

  // Compare timer: count, match handling, and software control; a hardware set of expired beats a clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count       <= 32'd0;
      tmr_en      <= 1'b0;
      tmr_auto    <= 1'b0;
      tmr_expired <= 1'b0;
      tmr_irq_en  <= 1'b0;
    end else begin
      if (tmr_en) begin
        if (hw_match) begin
          if (tmr_auto) count <= 32'd0;
          else          tmr_en <= 1'b0;
        end else begin
          count <= count + 32'd1;
        end
      end

      if (wr_commit && (acc_reg == REG_CTRL)) begin
        tmr_en     <= merged[0];
        tmr_auto   <= merged[1];
        tmr_irq_en <= merged[3];
        if (merged[0] && !tmr_en) count <= 32'd0;
      end

      if (hw_match)
        tmr_expired <= 1'b1;
      else if (wr_commit && (acc_reg == REG_CTRL) && acc_be[0] && acc_data[2])
        tmr_expired <= 1'b0;
    end
  end

  // Registered interrupt output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) irq <= 1'b0;
    else        irq <= tmr_expired & tmr_irq_en;
  end

  assign LEDR_output = ledr;
  assign HEX_value   = hex;

endmodule
